aes_iter_core: RTL and testbench

Iterative, parametrised AES encryption core that computes one full AES round per clock, with valid/ready handshakes on input and output. It replaces the two-round combinational datapath as the production encryption engine, supports AES-128/192/256 round counts, and is fed by an upstream key-expansion block that supplies all round keys in parallel.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_round.sv | 34 +++
 rtl/aes_iter_core.sv | 83 ++++++++
 tb/tb_aes_iter_core.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES block width, FIPS-197 S-box, GF(2^8) column helpers and core FSM state type
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } aes_fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 are rows 0..3, a0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on final), AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 final_round,
    output logic [AES_BLK_W-1:0] next_state
);

    logic [AES_BLK_W-1:0] sub_bytes;
    logic [AES_BLK_W-1:0] shift_rows;
    logic [AES_BLK_W-1:0] mix_cols;

    // Byte k (k = 4*col + row) lives at bits [127-8k -: 8].
    always_comb begin
        sub_bytes  = '0;
        shift_rows = '0;
        mix_cols   = '0;
        for (int k = 0; k < 16; k++) begin
            sub_bytes[127-8*k -: 8] = SBOX[state[127-8*k -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
        end
        next_state = (final_round ? shift_rows : mix_cols) ^ round_key;
    end

endmodule

// File: rtl/aes_iter_core.sv
// rtl/aes_iter_core.sv - iterative AES encryption core, one round per clock, valid/ready in and out
module aes_iter_core
    import aes_pkg::*;
#(
    parameter  int NR  = 10,
    localparam int RKW = AES_BLK_W * (NR + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [RKW-1:0]       round_keys,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic                 busy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_iter_core: NR must be 10, 12 or 14");
    end

    aes_fsm_e             fsm_q;
    aes_fsm_e             fsm_d;
    logic [AES_BLK_W-1:0] state_q;
    logic [3:0]           rnd_q;
    logic [AES_BLK_W-1:0] round_key;
    logic [AES_BLK_W-1:0] round_out;
    logic                 last_round;

    assign round_key  = round_keys[AES_BLK_W*int'(rnd_q) +: AES_BLK_W];
    assign last_round = (rnd_q == 4'(NR));
    assign ciphertext = state_q;

    aes_round u_round (
        .state       (state_q),
        .round_key   (round_key),
        .final_round (last_round),
        .next_state  (round_out)
    );

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) fsm_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (last_round) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // rnd_q returns to 0 after the final round so the key mux never indexes past round NR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (fsm_q == ST_IDLE && in_valid) begin
                state_q <= plaintext ^ round_keys[AES_BLK_W-1:0];
                rnd_q   <= 4'd1;
            end else if (fsm_q == ST_ROUND) begin
                state_q <= round_out;
                rnd_q   <= last_round ? 4'd0 : rnd_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// tb/tb_aes_iter_core.sv - scoreboard bench for aes_iter_core with an arithmetic AES reference model
module tb_aes_iter_core;

    parameter int NR = 10;
    localparam int RKW = 128 * (NR + 1);
    localparam int NK  = NR - 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [127:0]     plaintext = '0;
    logic [RKW-1:0]   round_keys = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [127:0]     ciphertext;

    aes_iter_core #(.NR(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [7:0]   sbox [256];
    logic [255:0] cur_key = '0;
    logic         kat_pending = 1'b0;
    logic [127:0] kat_ct = '0;
    logic         b2b = 1'b0;
    logic         have_last = 1'b0;
    int           last_out = 0;
    logic         ov_prev = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [RKW-1:0] expand(input logic [255:0] key);
        logic [31:0]    w [4*(NR+1)];
        logic [31:0]    t;
        logic [7:0]     rcon;
        logic [RKW-1:0] rk;
        rcon = 8'h01;
        rk   = '0;
        for (int i = 0; i < 4*(NR+1); i++) begin
            if (i < NK) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end else if (NK > 6 && i % NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [255:0] key);
        logic [RKW-1:0] rk;
        logic [7:0]     s [16];
        logic [7:0]     t [16];
        logic [7:0]     a [4];
        logic [127:0]   k;
        logic [127:0]   res;
        rk = expand(key);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= NR; rnd++) begin
            k = rk[128*rnd +: 128];
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < NR) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                        for (int r = 0; r < 4; r++)
                            s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic set_key(input logic [255:0] key);
        cur_key    = key;
        round_keys = expand(key);
    endtask

    task automatic send(input logic [127:0] pt);
        int n;
        n = 0;
        plaintext = pt;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                chk("accept_timeout", 128'(in_ready), 128'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 128'(sb_q.size()), 128'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic kat(input logic [127:0] pt, input logic [127:0] ct);
        kat_ct      = ct;
        kat_pending = 1'b1;
        send(pt);
        drain();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: expected pushed at each accept, popped and compared at each output handshake.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) begin
                    e.ct        = kat_pending ? kat_ct : encrypt(plaintext, cur_key);
                    e.cyc       = cyc;
                    kat_pending = 1'b0;
                    sb_q.push_back(e);
                end
                if (out_valid && !ov_prev) begin
                    if (sb_q.size() == 0) chk("spurious_out_valid", 128'(out_valid), 128'd0);
                    else chk("latency", 128'(cyc - sb_q[0].cyc), 128'(NR + 1));
                end
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("ciphertext", ciphertext, e.ct);
                    if (b2b && have_last) chk("spacing", 128'(cyc - last_out), 128'(NR + 2));
                    last_out  = cyc;
                    have_last = 1'b1;
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] held;
        build_sbox();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_ciphertext", ciphertext, 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer vectors
        if (NR == 10) begin
            set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
            kat(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
            kat(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
        end else if (NR == 12) begin
            set_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
            kat(128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        end else begin
            set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
            kat(128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089);
        end

        // Backpressure in DONE with an extra in_valid pending
        set_key({rnd128(), rnd128()});
        out_ready = 1'b0;
        send(rnd128());
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        chk("bp_out_valid_seen", 128'(out_valid), 128'd1);
        held      = ciphertext;
        plaintext = rnd128();
        in_valid  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ciphertext_stable", ciphertext, held);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_busy", 128'(busy), 128'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_handshake", 128'(in_ready), 128'd0);
        send(plaintext);
        drain();

        // Reset during the fifth ROUND cycle
        send(rnd128());
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
        chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_ciphertext", ciphertext, 128'd0);
        repeat (NR + 4) begin
            @(negedge clk);
            chk("rst_mid_no_out_valid", 128'(out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        send(rnd128());
        drain();

        // Back-to-back random blocks, four keys
        for (int g = 0; g < 4; g++) begin
            set_key({rnd128(), rnd128()});
            have_last = 1'b0;
            b2b       = 1'b1;
            for (int i = 0; i < 25; i++) send(rnd128());
            drain();
            b2b = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
